// File: rtl/mvm_pkg.sv
// Shared types and helpers for the vector matrix-vector multiply sequencer.
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    EMIT
  } state_t;

  // Default element and accumulator types; the sequencer takes its default widths from these.
  typedef logic signed [7:0]  elem_t;
  typedef logic signed [23:0] acc_t;

  // Clamp a signed value into the range of an nbits-wide two's complement number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int nbits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (nbits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (nbits - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/vec_lane_dot.sv
// Combinational signed dot product of two Lanes-wide element vectors, full precision.
module vec_lane_dot #(
  parameter int Lanes   = 4,
  parameter int NBits   = 8,
  parameter int AccBits = 24
) (
  input  logic [Lanes-1:0][NBits-1:0] a,
  input  logic [Lanes-1:0][NBits-1:0] b,
  output logic signed [AccBits-1:0]   dot
);

  localparam int Pad = 1 << $clog2(Lanes);

  // Heap-ordered tree: leaves at [Pad, 2*Pad), root at index 1.
  logic signed [AccBits-1:0] node [2*Pad];

  assign node[0] = '0;

  generate
    for (genvar gi = 0; gi < Pad; gi++) begin : g_leaf
      if (gi < Lanes) begin : g_mul
        logic signed [NBits-1:0]   ea;
        logic signed [NBits-1:0]   eb;
        logic signed [2*NBits-1:0] prod;
        assign ea   = a[gi];
        assign eb   = b[gi];
        assign prod = ea * eb;
        assign node[Pad+gi] = AccBits'(prod);
      end else begin : g_pad
        assign node[Pad+gi] = '0;
      end
    end

    for (genvar gi = 1; gi < Pad; gi++) begin : g_tree
      assign node[gi] = node[2*gi] + node[2*gi+1];
    end
  endgenerate

  assign dot = node[1];

endmodule

// File: rtl/vec_mvm_sequencer.sv
// Reads each resident vector OutVecLen times from the vector FIFO and emits one saturated dot product per row.
module vec_mvm_sequencer
  import mvm_pkg::*;
#(
  parameter int InVecLen  = 8,
  parameter int OutVecLen = 2,
  parameter int Lanes     = 4,
  parameter int NBits     = $bits(elem_t),
  parameter int AccBits   = $bits(acc_t),
  parameter int Shift     = 0,
  localparam int Chunks   = InVecLen / Lanes,
  localparam int AddrW    = (OutVecLen * Chunks > 1) ? $clog2(OutVecLen * Chunks) : 1
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         vec_valid,
  input  logic [Lanes-1:0][NBits-1:0]  fifo_data,
  output logic                         fifo_rd_en,
  output logic                         fifo_wrap,
  output logic [AddrW-1:0]             w_addr,
  input  logic [Lanes-1:0][NBits-1:0]  w_data,
  output logic [NBits-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         vec_done
);

  localparam int RowW   = (OutVecLen > 1) ? $clog2(OutVecLen) : 1;
  localparam int ChunkW = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam logic [RowW-1:0]   LastRow   = RowW'(OutVecLen - 1);
  localparam logic [ChunkW-1:0] LastChunk = ChunkW'(Chunks - 1);

  state_t                      state_reg;
  logic [RowW-1:0]             row_reg;
  logic [ChunkW-1:0]           chunk_reg;
  logic [Lanes-1:0][NBits-1:0] stage_reg;
  logic                        mac_pend_reg;
  logic signed [AccBits-1:0]   acc_reg;
  logic signed [AccBits-1:0]   acc_next;
  logic signed [AccBits-1:0]   dot;
  logic [NBits-1:0]            out_data_reg;
  logic                        out_valid_reg;
  logic                        rd_en_reg;
  logic                        wrap_reg;
  logic [AddrW-1:0]            w_addr_reg;

  // The last chunk of every row rewinds, except on the final row where the FIFO moves on to the next vector.
  function automatic logic rd_for(input logic [RowW-1:0] r, input logic [ChunkW-1:0] c);
    return (c != LastChunk) || (r == LastRow);
  endfunction

  function automatic logic [AddrW-1:0] addr_for(input logic [RowW-1:0] r, input logic [ChunkW-1:0] c);
    return AddrW'(int'(r) * Chunks + int'(c));
  endfunction

  vec_lane_dot #(
    .Lanes  (Lanes),
    .NBits  (NBits),
    .AccBits(AccBits)
  ) u_dot (
    .a  (stage_reg),
    .b  (w_data),
    .dot(dot)
  );

  // The weight word arrives one cycle after its address, alongside the staged FIFO chunk.
  always_comb begin
    acc_next = acc_reg;
    if (mac_pend_reg) begin
      acc_next = acc_reg + dot;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg     <= IDLE;
      row_reg       <= '0;
      chunk_reg     <= '0;
      stage_reg     <= '0;
      mac_pend_reg  <= 1'b0;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      rd_en_reg     <= 1'b0;
      wrap_reg      <= 1'b0;
      w_addr_reg    <= '0;
    end else begin
      mac_pend_reg <= (state_reg == RUN);
      acc_reg      <= acc_next;
      rd_en_reg    <= 1'b0;
      wrap_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (vec_valid) begin
            state_reg  <= RUN;
            row_reg    <= '0;
            chunk_reg  <= '0;
            acc_reg    <= '0;
            rd_en_reg  <= rd_for('0, '0);
            wrap_reg   <= !rd_for('0, '0);
            w_addr_reg <= addr_for('0, '0);
          end
        end
        RUN: begin
          stage_reg <= fifo_data;
          if (chunk_reg == LastChunk) begin
            state_reg <= FLUSH;
          end else begin
            chunk_reg  <= chunk_reg + 1'b1;
            rd_en_reg  <= rd_for(row_reg, chunk_reg + 1'b1);
            wrap_reg   <= !rd_for(row_reg, chunk_reg + 1'b1);
            w_addr_reg <= addr_for(row_reg, chunk_reg + 1'b1);
          end
        end
        FLUSH: begin
          state_reg     <= EMIT;
          out_valid_reg <= 1'b1;
          out_data_reg  <= NBits'(sat(64'(acc_next >>> Shift), NBits));
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
            if (row_reg != LastRow) begin
              state_reg  <= RUN;
              row_reg    <= row_reg + 1'b1;
              chunk_reg  <= '0;
              rd_en_reg  <= rd_for(row_reg + 1'b1, '0);
              wrap_reg   <= !rd_for(row_reg + 1'b1, '0);
              w_addr_reg <= addr_for(row_reg + 1'b1, '0);
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en = rd_en_reg;
  assign fifo_wrap  = wrap_reg;
  assign w_addr     = w_addr_reg;
  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;
  assign vec_done   = out_valid_reg && out_ready && (row_reg == LastRow);

endmodule

// File: tb/tb_vec_mvm_sequencer.sv
// Bench for vec_mvm_sequencer: three configurations fed by a FIFO/ROM model, checked against a row-level dot-product model.
module tb_vec_mvm_sequencer;

  localparam int NI = 3;
  // Instance 0: defaults; 1: Shift=7; 2: Lanes=8 (one chunk per row), OutVecLen=3.
  localparam int LA [NI] = '{4, 4, 8};
  localparam int OA [NI] = '{2, 2, 3};
  localparam int SA [NI] = '{0, 7, 0};
  localparam int LITN [NI] = '{11, 2, 6};
  localparam int LIT0 [11] = '{8, 8, 36, -36, 127, -128, 36, -36, 8, 8, 8};
  localparam int LIT1 [2]  = '{127, -8};
  localparam int LIT2 [6]  = '{36, 72, -36, 8, 16, -8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [NI];
  logic        vec_valid [NI];
  logic [63:0] fifo_data [NI];
  logic        rd_en     [NI];
  logic        wrap      [NI];
  logic [1:0]  w_addr    [NI];
  logic [63:0] w_data    [NI];
  logic [7:0]  out_data  [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic        vec_done  [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int L = LA[gi];
    vec_mvm_sequencer #(
      .InVecLen (8),
      .OutVecLen(OA[gi]),
      .Lanes    (L),
      .NBits    (8),
      .AccBits  (24),
      .Shift    (SA[gi])
    ) u_dut (
      .clk_in    (clk),
      .rst_in    (rst[gi]),
      .vec_valid (vec_valid[gi]),
      .fifo_data (fifo_data[gi][L*8-1:0]),
      .fifo_rd_en(rd_en[gi]),
      .fifo_wrap (wrap[gi]),
      .w_addr    (w_addr[gi]),
      .w_data    (w_data[gi][L*8-1:0]),
      .out_data  (out_data[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .vec_done  (vec_done[gi])
    );
  end

  // FIFO and weight ROM models
  logic signed [7:0] mem [NI][64];
  logic [63:0]       rom [NI][4];
  int wr_ptr [NI];
  int rd_ptr [NI];
  int vstart [NI];

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      fifo_data[k] = '0;
      for (int l = 0; l < LA[k]; l++) fifo_data[k][l*8 +: 8] = mem[k][(rd_ptr[k] + l) % 64];
      vec_valid[k] = (wr_ptr[k] - vstart[k]) >= 8;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      w_data[k] <= rom[k][w_addr[k]];
      if (rst[k]) begin
        rd_ptr[k] <= 0;
        vstart[k] <= 0;
      end else if (wrap[k]) begin
        rd_ptr[k] <= vstart[k];
      end else if (rd_en[k]) begin
        rd_ptr[k] <= rd_ptr[k] + LA[k];
        if (rd_ptr[k] + LA[k] - vstart[k] >= 8) vstart[k] <= rd_ptr[k] + LA[k];
      end
    end
  end

  // Scoreboard state
  int compared = 0;
  int mismatched = 0;
  int row_m [NI];
  int base_m [NI];
  int sidx [NI];
  int lit_i [NI];
  bit rst_seen [NI];
  bit timeout_req = 1'b0;
  bit timeout_seen = 1'b0;
  bit end_req = 1'b0;
  bit end_ack = 1'b0;

  function automatic int lit_val(int k, int i);
    if (k == 0) return LIT0[i];
    if (k == 1) return LIT1[i];
    return LIT2[i];
  endfunction

  // Row result straight from the definition: saturate((sum of element*weight) >>> Shift).
  function automatic int exp_row(int k, int base, int r);
    int c;
    int sum;
    int w;
    int e;
    logic [63:0] word;
    c = 8 / LA[k];
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      word = rom[k][r*c + i/LA[k]];
      w = int'($signed(word[(i % LA[k])*8 +: 8]));
      e = int'(mem[k][(base + i) % 64]);
      sum += e * w;
    end
    sum = sum >>> SA[k];
    if (sum > 127) sum = 127;
    else if (sum < -128) sum = -128;
    return sum;
  endfunction

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s inst%0d t=%0t got=%0d want=%0d", name, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int c;
    int o;
    int r;
    int ch;
    bit exp_rd;
    bit exp_done;
    for (int k = 0; k < NI; k++) begin
      c = 8 / LA[k];
      o = OA[k];
      exp_done = 1'b0;
      if (rst_seen[k])
        chk("reset_outputs", k, {out_valid[k], rd_en[k], wrap[k], vec_done[k], out_data[k], w_addr[k]}, 0);
      if (rst[k]) begin
        rst_seen[k] = 1'b1;
        row_m[k] = 0;
        base_m[k] = 0;
        sidx[k] = 0;
      end else begin
        rst_seen[k] = 1'b0;
        if (rd_en[k] || wrap[k]) begin
          r = sidx[k] / c;
          ch = sidx[k] % c;
          exp_rd = (ch < c - 1) || (r == o - 1);
          chk("strobe", k, {rd_en[k], wrap[k]}, {exp_rd, !exp_rd});
          chk("w_addr", k, w_addr[k], r*c + ch);
          sidx[k] = (sidx[k] + 1 == o*c) ? 0 : sidx[k] + 1;
        end
        if (out_valid[k]) begin
          chk("strobe_in_emit", k, {rd_en[k], wrap[k]}, 0);
          chk("out_data", k, $signed(out_data[k]), exp_row(k, base_m[k], row_m[k]));
          if (out_ready[k]) begin
            if (lit_i[k] < LITN[k]) chk("pin", k, $signed(out_data[k]), lit_val(k, lit_i[k]));
            else chk("extra_output", k, lit_i[k], LITN[k] - 1);
            lit_i[k]++;
            if (row_m[k] == o - 1) begin
              row_m[k] = 0;
              base_m[k] += 8;
              exp_done = 1'b1;
            end else begin
              row_m[k]++;
            end
          end
        end
        chk("vec_done", k, vec_done[k], exp_done);
      end
    end
    if (timeout_req && !timeout_seen) begin
      timeout_seen = 1'b1;
      chk("timeout", 0, 1, 0);
    end
    if (end_req && !end_ack) begin
      for (int k = 0; k < NI; k++) begin
        chk("output_count", k, lit_i[k], LITN[k]);
        chk("strobes_per_vector", k, sidx[k], 0);
      end
      end_ack = 1'b1;
    end
  end

  // Stimulus helpers
  task automatic set_row(input int k, input int r, input int w);
    int c;
    c = 8 / LA[k];
    for (int ch = 0; ch < c; ch++) begin
      rom[k][r*c + ch] = '0;
      for (int l = 0; l < LA[k]; l++) rom[k][r*c + ch][l*8 +: 8] = 8'(w);
    end
  endtask

  // ramp=1 writes 1..8, otherwise every element is v.
  task automatic push_vec(input int k, input bit ramp, input int v);
    for (int i = 0; i < 8; i++) mem[k][(wr_ptr[k] + i) % 64] = ramp ? 8'(i + 1) : 8'(v);
    wr_ptr[k] += 8;
  endtask

  task automatic wait_done(input int k, input int n);
    int cnt;
    cnt = 0;
    for (int t = 0; t < 300 && cnt < n; t++) begin
      @(negedge clk);
      if (vec_done[k]) cnt++;
    end
    if (cnt < n) begin
      $display("FAIL wait_done inst%0d got=%0d want=%0d", k, cnt, n);
      timeout_req = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int k);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid[k] && out_ready[k];
    end
    if (!seen) begin
      $display("FAIL wait_accept inst%0d got=0 want=1", k);
      timeout_req = 1'b1;
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      out_ready[k] = 1'b1;
      wr_ptr[k] = 0;
      for (int a = 0; a < 4; a++) rom[k][a] = '0;
      for (int a = 0; a < 64; a++) mem[k][a] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;

    // All ones: 8, 8
    set_row(0, 0, 1); set_row(0, 1, 1);
    push_vec(0, 1'b0, 1);
    wait_done(0, 1);

    // Ramp against +1 / -1 rows: 36, -36
    set_row(0, 0, 1); set_row(0, 1, -1);
    push_vec(0, 1'b1, 0);
    wait_done(0, 1);

    // Saturation both ways: 127, -128
    set_row(0, 0, 127); set_row(0, 1, -128);
    push_vec(0, 1'b0, 127);
    wait_done(0, 1);

    // Backpressure: hold out_ready low for 5 cycles once the first row is presented
    set_row(0, 0, 1); set_row(0, 1, -1);
    out_ready[0] = 1'b0;
    push_vec(0, 1'b1, 0);
    for (int t = 0; t < 100 && !out_valid[0]; t++) @(negedge clk);
    repeat (5) @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    wait_done(0, 1);

    // Reset during the second RUN cycle of row 1, then a fresh vector
    set_row(0, 0, 1); set_row(0, 1, 1);
    push_vec(0, 1'b0, 1);
    wait_accept(0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    wr_ptr[0] = 0;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    push_vec(0, 1'b0, 1);
    wait_done(0, 1);

    // Shift=7: 129032>>>7 saturates to 127, -1016>>>7 = -8
    set_row(1, 0, 127); set_row(1, 1, -1);
    push_vec(1, 1'b0, 127);
    wait_done(1, 1);

    // One chunk per row, three rows, two vectors back to back
    set_row(2, 0, 1); set_row(2, 1, 2); set_row(2, 2, -1);
    push_vec(2, 1'b1, 0);
    push_vec(2, 1'b0, 1);
    wait_done(2, 2);

    repeat (4) @(posedge clk);
    end_req = 1'b1;
    for (int t = 0; t < 10 && !end_ack; t++) @(posedge clk);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
